bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Parametrised successor to the 4-digit 10 Hz up-counter. Provides a DIGITS-wide BCD up/down counter with programmable modulus, an internal tick prescaler, debounced-edge run/stop toggle, synchronous clear and parallel load.
- Runs entirely in the clk domain. There are no derived clocks; count advance is gated by a one-cycle tick enable.
- Output feeds the FND controller directly as packed BCD digits.

Parameters:
- CLK_HZ, 100_000_000: frequency of clk in Hz.
- TICK_HZ, 10: count rate in Hz. The prescaler divisor is DIV = CLK_HZ/TICK_HZ. DIV must be ≥ 2.
- DIGITS, 4: number of BCD digits. Range 1..8.
- MAX_COUNT, 9999: terminal value. The count runs over 0..MAX_COUNT. MAX_COUNT must be < 10**DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run_toggle  in  1  asynchronous button level; each rising edge toggles run/stop
- clear  in  1  synchronous clear, level, active-high
- dir  in  1  0 = count up, 1 = count down
- load  in  1  synchronous parallel load strobe
- load_val  in  4*DIGITS  BCD value to load; digit 0 is in bits [3:0]
- bcd  out  4*DIGITS  current count, packed BCD, digit 0 is LSD
- running  out  1  1 = counting enabled
- tick  out  1  one-clk pulse at each count step (combinational from prescaler and running)
- wrap  out  1  registered one-clk pulse on modulus wrap

Behaviour:
- Reset (rst=1, async): bcd=0, running=0, wrap=0, prescaler=0, synchronizer flops=0. tick=0 while rst is held.
- run_toggle path:
  - Passes through a 2-flop synchronizer, then a rising-edge detect (sync2 & ~prev).
  - running flips on the 3rd rising clk edge after run_toggle rises.
  - A held-high level toggles once only. Bounce filtering is upstream.
- Prescaler:
  - Counts 0..DIV-1 only while running=1. Holds its value while running=0 (pause/resume keeps phase).
  - tick = running && (prescaler == DIV-1). The prescaler returns to 0 on that edge.
  - The first step after start occurs DIV cycles after running rises from a reset prescaler.
- Count step on the edge where tick=1:
  - Up: ripple BCD increment, each digit 0..9. At bcd == MAX_COUNT (BCD form), the next value is 0 and wrap=1 for one cycle.
  - Down: BCD decrement with borrow. At bcd == 0, the next value is MAX_COUNT and wrap=1 for one cycle.
  - dir is sampled only at tick. A dir change mid-interval affects the next step only.
- Priority on the same edge: clear > load > tick step.
  - clear: bcd=0 and prescaler=0. running is unchanged. wrap=0.
  - load: bcd=load_val and prescaler=0. running is unchanged. wrap=0.
  - Load of an invalid value (any digit > 9, or value > MAX_COUNT): the value is loaded as-is. The next up step forces it to 0 with wrap=1. The next down step decrements digit-wise, with any digit > 9 treated as 9.
  - A toggle edge on the same cycle as clear or load still toggles running.
- wrap defaults to 0 on every cycle with no wrapping step.
- bcd changes only on the clear, load or tick edge. It is glitch-free (registered).
- Parameter violations (DIV < 2, MAX_COUNT ≥ 10**DIGITS) must stop elaboration (generate-time error).

Test Plan (bench parameters: CLK_HZ=100, TICK_HZ=10 so DIV=10; DIGITS=4; MAX_COUNT=9999 unless noted):
- Reset then run_toggle pulse -> running=1 on the 3rd clk edge. bcd=0001 after 10 further clks. bcd=0005 after 50 clks. tick is high exactly 1 cycle in every 10.
- Load 9998, dir=0, running -> steps to 9999, then 0000 with wrap=1 for exactly one clk. Down run from 0000 -> 9999 with wrap=1.
- MAX_COUNT=59, DIGITS=2, up from 58 -> 59 -> 00 with wrap. Down from 00 -> 59.
- Pause: toggle off at prescaler=4, wait 100 clks, toggle on -> bcd holds throughout. The next step occurs 6 clks after running=1.
- Same edge clear+load+tick -> bcd=0, wrap=0. Load alone with tick -> bcd=load_val. Clear with toggle edge -> bcd=0 and running flips.
- Assert rst mid-count (bcd=0123, running=1) -> immediately bcd=0, running=0, tick=0. After release, no counting until a new toggle.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// DIGITS-wide packed-BCD up/down counter with programmable modulus, tick prescaler,
// synchronized run/stop toggle, synchronous clear and parallel load.
module bcd_updown_counter #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned TICK_HZ   = 10,
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned MAX_COUNT = 9999
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_toggle,
   input  logic                  clear,
   input  logic                  dir,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  running,
   output logic                  tick,
   output logic                  wrap
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV < 32'd2) ? 32'd1 : $clog2(DIV);
   localparam int unsigned BW  = 4 * DIGITS;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < int'(n); i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   function automatic logic [BW-1:0] to_bcd(input int unsigned v);
      logic [BW-1:0] r;
      int unsigned   t;
      r = '0;
      t = v;
      for (int i = 0; i < int'(DIGITS); i++) begin
         r[4*i +: 4] = 4'(t % 32'd10);
         t           = t / 32'd10;
      end
      return r;
   endfunction

   localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
   localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 32'd1);

   if (DIV < 32'd2) begin : g_bad_div
      $error("bcd_updown_counter: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (DIGITS < 32'd1 || DIGITS > 32'd8) begin : g_bad_digits
      $error("bcd_updown_counter: DIGITS must be in 1..8");
   end
   if (longint'(MAX_COUNT) >= pow10(DIGITS)) begin : g_bad_max
      $error("bcd_updown_counter: MAX_COUNT does not fit in DIGITS digits");
   end

   function automatic logic has_bad_digit(input logic [BW-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction

   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Digits above 9 are clamped to 9 before the borrow chain runs.
   function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic [3:0]    d;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         d = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            r[4*i +: 4] = d;
         end
      end
      return r;
   endfunction

   logic          sync1_r;
   logic          sync2_r;
   logic          prev_r;
   logic          running_r;
   logic [PW-1:0] presc_r;
   logic [BW-1:0] bcd_r;
   logic          wrap_r;

   logic          toggle_s;
   logic          tick_s;
   logic          up_wrap_s;
   logic          dn_wrap_s;
   logic [PW-1:0] presc_nxt_s;
   logic [BW-1:0] bcd_nxt_s;
   logic          wrap_nxt_s;

   assign toggle_s  = sync2_r & ~prev_r;
   assign tick_s    = running_r && (presc_r == DIV_M1);
   assign up_wrap_s = has_bad_digit(bcd_r) || (bcd_r >= MAX_BCD);
   assign dn_wrap_s = (bcd_r == '0);

   // Prescaler next state: cleared by clear/load, advances only while running.
   always_comb begin
      presc_nxt_s = presc_r;
      if (clear || load) begin
         presc_nxt_s = '0;
      end else if (tick_s) begin
         presc_nxt_s = '0;
      end else if (running_r) begin
         presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         presc_nxt_s = presc_r;
      end
   end

   // Count next state with clear > load > tick step priority.
   always_comb begin
      bcd_nxt_s  = bcd_r;
      wrap_nxt_s = 1'b0;
      if (clear) begin
         bcd_nxt_s = '0;
      end else if (load) begin
         bcd_nxt_s = load_val;
      end else if (tick_s) begin
         case (dir)
            1'b0: begin
               if (up_wrap_s) begin
                  bcd_nxt_s  = '0;
                  wrap_nxt_s = 1'b1;
               end else begin
                  bcd_nxt_s  = bcd_inc(bcd_r);
               end
            end
            1'b1: begin
               if (dn_wrap_s) begin
                  bcd_nxt_s  = MAX_BCD;
                  wrap_nxt_s = 1'b1;
               end else begin
                  bcd_nxt_s  = bcd_dec(bcd_r);
               end
            end
            default: begin
               bcd_nxt_s = bcd_r;
            end
         endcase
      end else begin
         bcd_nxt_s = bcd_r;
      end
   end

   // Toggle synchronizer, edge history and run flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         prev_r    <= 1'b0;
         running_r <= 1'b0;
      end else begin
         sync1_r   <= run_toggle;
         sync2_r   <= sync1_r;
         prev_r    <= sync2_r;
         running_r <= running_r ^ toggle_s;
      end
   end

   // Prescaler, count and wrap registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= '0;
         bcd_r   <= '0;
         wrap_r  <= 1'b0;
      end else begin
         presc_r <= presc_nxt_s;
         bcd_r   <= bcd_nxt_s;
         wrap_r  <= wrap_nxt_s;
      end
   end

   assign bcd     = bcd_r;
   assign running = running_r;
   assign tick    = tick_s;
   assign wrap    = wrap_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a 4-digit/9999 instance and a 2-digit/59 instance,
// both at DIV=10.
module tb_bcd_updown_counter;

   logic        clk;
   logic        rst, run_toggle, clear, dir, load;
   logic [15:0] load_val, bcd;
   logic        running, tick, wrap;

   logic        rst_b, run_toggle_b, clear_b, dir_b, load_b;
   logic [7:0]  load_val_b, bcd_b;
   logic        running_b, tick_b, wrap_b;

   int n_assert = 0;
   int n_fail   = 0;
   int tick_cnt;

   bcd_updown_counter #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .MAX_COUNT(9999)) dut (
      .clk(clk), .rst(rst), .run_toggle(run_toggle), .clear(clear), .dir(dir),
      .load(load), .load_val(load_val), .bcd(bcd), .running(running), .tick(tick), .wrap(wrap)
   );

   bcd_updown_counter #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(2), .MAX_COUNT(59)) dut_b (
      .clk(clk), .rst(rst_b), .run_toggle(run_toggle_b), .clear(clear_b), .dir(dir_b),
      .load(load_b), .load_val(load_val_b), .bcd(bcd_b), .running(running_b), .tick(tick_b),
      .wrap(wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges and settle 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cyc_count_ticks(input int n);
      tick_cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (tick) tick_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; run_toggle = 1'b0; clear = 1'b0; dir = 1'b0; load = 1'b0; load_val = 16'h0000;
      rst_b = 1'b1; run_toggle_b = 1'b0; clear_b = 1'b0; dir_b = 1'b0; load_b = 1'b0;
      load_val_b = 8'h00;
      cyc(3);
      chk("reset_bcd", 32'(bcd), 32'h0);
      chk("reset_running", 32'(running), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      chk("reset_wrap", 32'(wrap), 32'h0);
      rst = 1'b0; rst_b = 1'b0;
      cyc(2);

      // Start: running flips on the third edge after the toggle rises.
      run_toggle = 1'b1;
      cyc(2);
      chk("start_not_yet", 32'(running), 32'h0);
      cyc(1);
      chk("start_running", 32'(running), 32'h1);
      cyc(4);
      run_toggle = 1'b0;
      chk("held_toggles_once", 32'(running), 32'h1);
      cyc(5);
      chk("first_tick", 32'(tick), 32'h1);
      chk("first_tick_bcd", 32'(bcd), 32'h0000);
      cyc(1);
      chk("first_step", 32'(bcd), 32'h0001);
      cyc_count_ticks(40);
      chk("tick_every_10", 32'(tick_cnt), 32'd4);
      chk("bcd_after_50", 32'(bcd), 32'h0005);

      // Up wrap 9998 -> 9999 -> 0000.
      load = 1'b1; load_val = 16'h9998;
      cyc(1);
      load = 1'b0;
      chk("load_9998", 32'(bcd), 32'h9998);
      cyc(10);
      chk("up_9999", 32'(bcd), 32'h9999);
      chk("up_9999_nowrap", 32'(wrap), 32'h0);
      cyc(10);
      chk("up_wrap_bcd", 32'(bcd), 32'h0000);
      chk("up_wrap_pulse", 32'(wrap), 32'h1);
      cyc(1);
      chk("up_wrap_one_clk", 32'(wrap), 32'h0);

      // Down wrap 0000 -> 9999.
      dir = 1'b1; load = 1'b1; load_val = 16'h0000;
      cyc(1);
      load = 1'b0;
      cyc(10);
      chk("dn_wrap_bcd", 32'(bcd), 32'h9999);
      chk("dn_wrap_pulse", 32'(wrap), 32'h1);
      cyc(1);
      chk("dn_wrap_one_clk", 32'(wrap), 32'h0);
      dir = 1'b0;
      cyc(9);
      chk("dir_mid_interval", 32'(bcd), 32'h0000);
      chk("dir_mid_wrap", 32'(wrap), 32'h1);

      // Pause with prescaler held at 4, then resume.
      load = 1'b1; load_val = 16'h0123;
      cyc(1);
      load = 1'b0;
      cyc(1);
      run_toggle = 1'b1;
      cyc(3);
      chk("pause_stopped", 32'(running), 32'h0);
      run_toggle = 1'b0;
      cyc_count_ticks(100);
      chk("pause_no_ticks", 32'(tick_cnt), 32'd0);
      chk("pause_hold", 32'(bcd), 32'h0123);
      run_toggle = 1'b1;
      cyc(3);
      chk("resume_running", 32'(running), 32'h1);
      run_toggle = 1'b0;
      cyc(5);
      chk("resume_tick", 32'(tick), 32'h1);
      chk("resume_hold", 32'(bcd), 32'h0123);
      cyc(1);
      chk("resume_step", 32'(bcd), 32'h0124);

      // Priority: clear beats load and tick; load beats tick.
      cyc(9);
      chk("prio_tick_ready", 32'(tick), 32'h1);
      clear = 1'b1; load = 1'b1; load_val = 16'h4321;
      cyc(1);
      clear = 1'b0; load = 1'b0;
      chk("clr_load_tick_bcd", 32'(bcd), 32'h0000);
      chk("clr_load_tick_wrap", 32'(wrap), 32'h0);
      chk("clr_keeps_running", 32'(running), 32'h1);
      cyc(9);
      chk("clr_resets_presc", 32'(tick), 32'h1);
      load = 1'b1; load_val = 16'h0456;
      cyc(1);
      load = 1'b0;
      chk("load_over_tick", 32'(bcd), 32'h0456);
      run_toggle = 1'b1;
      cyc(2);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0; run_toggle = 1'b0;
      chk("clr_toggle_bcd", 32'(bcd), 32'h0000);
      chk("clr_toggle_running", 32'(running), 32'h0);

      // Invalid loads: down clamps bad digits to 9, up forces 0 with wrap.
      dir = 1'b1; load = 1'b1; load_val = 16'h0A05;
      cyc(1);
      load = 1'b0;
      chk("load_invalid", 32'(bcd), 32'h0A05);
      run_toggle = 1'b1;
      cyc(3);
      run_toggle = 1'b0;
      chk("restart_running", 32'(running), 32'h1);
      cyc(10);
      chk("invalid_down", 32'(bcd), 32'h0904);
      chk("invalid_down_nowrap", 32'(wrap), 32'h0);
      dir = 1'b0; load = 1'b1; load_val = 16'h00C0;
      cyc(1);
      load = 1'b0;
      cyc(10);
      chk("invalid_up_bcd", 32'(bcd), 32'h0000);
      chk("invalid_up_wrap", 32'(wrap), 32'h1);

      // Asynchronous reset mid-count.
      load = 1'b1; load_val = 16'h0123;
      cyc(1);
      load = 1'b0;
      cyc(9);
      chk("pre_rst_tick", 32'(tick), 32'h1);
      chk("pre_rst_bcd", 32'(bcd), 32'h0123);
      rst = 1'b1;
      #1;
      chk("rst_bcd", 32'(bcd), 32'h0000);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc_count_ticks(30);
      chk("post_rst_no_ticks", 32'(tick_cnt), 32'd0);
      chk("post_rst_bcd", 32'(bcd), 32'h0000);
      chk("post_rst_stopped", 32'(running), 32'h0);

      // Two-digit modulus 59.
      load_b = 1'b1; load_val_b = 8'h58;
      cyc(1);
      load_b = 1'b0;
      chk("m59_load", 32'(bcd_b), 32'h58);
      run_toggle_b = 1'b1;
      cyc(3);
      run_toggle_b = 1'b0;
      chk("m59_running", 32'(running_b), 32'h1);
      cyc(10);
      chk("m59_up_59", 32'(bcd_b), 32'h59);
      chk("m59_up_nowrap", 32'(wrap_b), 32'h0);
      cyc(10);
      chk("m59_up_wrap_bcd", 32'(bcd_b), 32'h00);
      chk("m59_up_wrap", 32'(wrap_b), 32'h1);
      dir_b = 1'b1;
      cyc(10);
      chk("m59_dn_wrap_bcd", 32'(bcd_b), 32'h59);
      chk("m59_dn_wrap", 32'(wrap_b), 32'h1);
      cyc(10);
      chk("m59_dn_58", 32'(bcd_b), 32'h58);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
